// File: rtl/mac_operand_sequencer.sv
// Streams word pairs from two operand BRAMs through a 4-lane mac_unit and sums the partial results.
// Optional macro MAC_SEQ_SATURATE_EN: saturate the accumulator and raise a sticky overflow flag.
module mac_operand_sequencer #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int ACC_WIDTH    = 48,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr_a,
  input  logic [ADDR_WIDTH-1:0]   base_addr_b,
  input  logic [ADDR_WIDTH-1:0]   num_words,
  output logic                    busy,
  output logic                    done,
  output logic [ACC_WIDTH-1:0]    dot_result,
  output logic                    overflow,
  output logic                    enb,
  output logic [ADDR_WIDTH-1:0]   addrb_a,
  output logic [ADDR_WIDTH-1:0]   addrb_b,
  input  logic [63:0]             bram_dout_a,
  input  logic [63:0]             bram_dout_b,
  output logic [63:0]             doutb_a,
  output logic [63:0]             doutb_b,
  output logic                    start_mac,
  input  logic                    status_done,
  input  logic [2*DATA_WIDTH-1:0] mac_result
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    RDWAIT,
    LAUNCH,
    MACWAIT,
    ACCUM,
    DONE
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] base_a, base_b, count, idx, idx_inc;
  logic [1:0]            wait_cnt;
  logic                  mac_first;
  logic                  rd_ready;
  logic                  last_word;
  logic [ACC_WIDTH:0]    sum_ext;

  assign idx_inc   = idx + ADDR_WIDTH'(1);
  assign last_word = (idx_inc == count);
  assign rd_ready  = (wait_cnt == 2'(READ_LATENCY - 1));
  // One extra bit exposes the carry out of the accumulator.
  assign sum_ext   = {1'b0, dot_result} + (ACC_WIDTH + 1)'(mac_result);

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    enb        = 1'b0;
    start_mac  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = (num_words == '0) ? DONE : READ;
      end
      READ: begin
        enb        = 1'b1;
        state_next = RDWAIT;
      end
      RDWAIT: begin
        if (rd_ready) state_next = LAUNCH;
      end
      LAUNCH: begin
        start_mac  = 1'b1;
        state_next = MACWAIT;
      end
      MACWAIT: begin
        // The first cycle may still see the previous word's done level.
        if (!mac_first && status_done) state_next = ACCUM;
      end
      ACCUM: begin
        state_next = last_word ? DONE : READ;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      base_a     <= '0;
      base_b     <= '0;
      count      <= '0;
      idx        <= '0;
      wait_cnt   <= '0;
      mac_first  <= 1'b0;
      dot_result <= '0;
      overflow   <= 1'b0;
      addrb_a    <= '0;
      addrb_b    <= '0;
      doutb_a    <= '0;
      doutb_b    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            base_a     <= base_addr_a;
            base_b     <= base_addr_b;
            count      <= num_words;
            idx        <= '0;
            dot_result <= '0;
            overflow   <= 1'b0;
            addrb_a    <= base_addr_a;
            addrb_b    <= base_addr_b;
          end
        end
        READ: begin
          wait_cnt <= '0;
        end
        RDWAIT: begin
          if (rd_ready) begin
            doutb_a <= bram_dout_a;
            doutb_b <= bram_dout_b;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        LAUNCH: begin
          mac_first <= 1'b1;
        end
        MACWAIT: begin
          mac_first <= 1'b0;
        end
        ACCUM: begin
          idx     <= idx_inc;
          addrb_a <= base_a + idx_inc;
          addrb_b <= base_b + idx_inc;
`ifdef MAC_SEQ_SATURATE_EN
          if (sum_ext[ACC_WIDTH]) begin
            dot_result <= '1;
            overflow   <= 1'b1;
          end else begin
            dot_result <= sum_ext[ACC_WIDTH-1:0];
          end
`else
          dot_result <= sum_ext[ACC_WIDTH-1:0];
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Randomized bench for mac_operand_sequencer with BRAM and mac_unit behavioural models.
// Expected results come from a direct dot-product reference over the BRAM contents.
module tb_mac_operand_sequencer;

  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int ACC = 33;
  localparam logic [63:0] ACC_MAX = (64'd1 << ACC) - 64'd1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr_a = '0, base_addr_b = '0, num_words = '0;
  logic          busy, done, overflow, enb, start_mac;
  logic [ACC-1:0] dot_result;
  logic [AW-1:0] addrb_a, addrb_b;
  logic [63:0]   bram_dout_a = '0, bram_dout_b = '0;
  logic [63:0]   doutb_a, doutb_b;
  logic          status_done = 1'b0;
  logic [2*DW-1:0] mac_result = '0;

  logic [63:0] mem_a [256];
  logic [63:0] mem_b [256];
  logic        ff_mode = 1'b0;
  logic [63:0] op_a = '0, op_b = '0;
  int          mac_cnt = 0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  mac_operand_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACC_WIDTH(ACC), .READ_LATENCY(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_addr_a(base_addr_a), .base_addr_b(base_addr_b), .num_words(num_words),
    .busy(busy), .done(done), .dot_result(dot_result), .overflow(overflow),
    .enb(enb), .addrb_a(addrb_a), .addrb_b(addrb_b),
    .bram_dout_a(bram_dout_a), .bram_dout_b(bram_dout_b),
    .doutb_a(doutb_a), .doutb_b(doutb_b),
    .start_mac(start_mac), .status_done(status_done), .mac_result(mac_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAMs with one cycle of read latency
  always @(posedge clk) begin
    if (enb) begin
      bram_dout_a <= mem_a[addrb_a];
      bram_dout_b <= mem_b[addrb_b];
    end
  end

  function automatic logic [31:0] lane_dot(input logic [63:0] a, input logic [63:0] b);
    logic [31:0] s;
    s = '0;
    for (int l = 0; l < 4; l++) s += 32'(a[16*l +: 16]) * 32'(b[16*l +: 16]);
    return s;
  endfunction

  // mac_unit: done level stays high until the cycle after the next start_mac,
  // then rises again with the new result 3 cycles after start_mac.
  always @(posedge clk) begin
    if (start_mac) begin
      mac_cnt <= 1;
      op_a    <= doutb_a;
      op_b    <= doutb_b;
    end else if (mac_cnt == 1) begin
      status_done <= 1'b0;
      mac_cnt     <= 2;
    end else if (mac_cnt == 2) begin
      status_done <= 1'b1;
      mac_result  <= ff_mode ? 32'hFFFF_FFFF : lane_dot(op_a, op_b);
      mac_cnt     <= 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_model(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] n,
                           output logic [63:0] dot, output logic ovf);
    logic [63:0] acc, p, a, b;
    acc = '0;
    ovf = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      a = mem_a[8'(ba + 8'(i))];
      b = mem_b[8'(bb + 8'(i))];
      if (ff_mode) p = 64'hFFFF_FFFF;
      else begin
        p = '0;
        for (int l = 0; l < 4; l++) p += 64'(a[16*l +: 16]) * 64'(b[16*l +: 16]);
        p = p & 64'hFFFF_FFFF;
      end
      acc += p;
      if (acc > ACC_MAX) begin
`ifdef MAC_SEQ_SATURATE_EN
        acc = ACC_MAX;
        ovf = 1'b1;
`else
        acc = acc - (ACC_MAX + 64'd1);
`endif
      end
    end
    dot = acc;
  endtask

  task automatic check_zero_state(input string tag);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_enb"}, 64'(enb), 0);
    check({tag, "_smac"}, 64'(start_mac), 0);
    check({tag, "_ovf"}, 64'(overflow), 0);
    check({tag, "_dot"}, 64'(dot_result), 0);
    check({tag, "_addra"}, 64'(addrb_a), 0);
    check({tag, "_addrb"}, 64'(addrb_b), 0);
    check({tag, "_douta"}, doutb_a, 0);
    check({tag, "_doutb"}, doutb_b, 0);
  endtask

  // Called at a negedge; returns at the negedge of the idle cycle after done.
  task automatic do_op(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] n,
                       input logic noise);
    logic [63:0] exp_dot;
    logic        exp_ovf, seen, bad_busy;
    logic [7:0]  qa[$], qb[$];
    logic [63:0] da[$], db[$];
    int          t0, lat;
    ref_model(ba, bb, n, exp_dot, exp_ovf);
    start = 1'b1; base_addr_a = ba; base_addr_b = bb; num_words = n;
    t0 = cyc; lat = -1; seen = 1'b0; bad_busy = 1'b0;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(negedge clk);
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      base_addr_a = 8'($urandom); base_addr_b = 8'($urandom); num_words = 8'($urandom);
      if (!busy) bad_busy = 1'b1;
      if (enb) begin qa.push_back(addrb_a); qb.push_back(addrb_b); end
      if (start_mac) begin da.push_back(doutb_a); db.push_back(doutb_b); end
      if (done) begin seen = 1'b1; lat = cyc - t0; end
    end
    check("done_seen", 64'(seen), 1);
    check("latency", 64'(lat), 64'(int'(n) * 7 + 1));
    check("busy_run", 64'(bad_busy), 0);
    check("dot", 64'(dot_result), exp_dot);
    check("ovf", 64'(overflow), 64'(exp_ovf));
    check("enb_cnt", 64'(qa.size()), 64'(n));
    check("smac_cnt", 64'(da.size()), 64'(n));
    for (int i = 0; i < qa.size() && i < int'(n); i++) begin
      check("addr_a", 64'(qa[i]), 64'(8'(ba + 8'(i))));
      check("addr_b", 64'(qb[i]), 64'(8'(bb + 8'(i))));
    end
    for (int i = 0; i < da.size() && i < int'(n); i++) begin
      check("opnd_a", da[i], mem_a[8'(ba + 8'(i))]);
      check("opnd_b", db[i], mem_b[8'(bb + 8'(i))]);
    end
    @(negedge clk);
    start = 1'b0;
    check("idle_busy", 64'(busy), 0);
    check("idle_done", 64'(done), 0);
    check("hold_dot", 64'(dot_result), exp_dot);
    $display("[TB] op ba=%h bb=%h n=%0d dot=%h exp=%h ovf=%b lat=%0d", ba, bb, n,
             dot_result, exp_dot, overflow, lat);
  endtask

  task automatic do_abort(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] n);
    logic seen;
    start = 1'b1; base_addr_a = ba; base_addr_b = bb; num_words = n;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (start_mac) seen = 1'b1;
    end
    check("abort_smac_seen", 64'(seen), 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_zero_state("abort");
    $display("[TB] abort ba=%h bb=%h n=%0d busy=%b dot=%h", ba, bb, n, busy, dot_result);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = {$urandom, $urandom};
      mem_b[i] = {$urandom, $urandom};
    end
    mem_a[8'h10] = 64'h0004_0003_0002_0001;
    mem_b[8'h10] = 64'h0005_0004_0003_0002;
    mem_a[8'h11] = 64'h0001_0001_0001_0001;
    mem_b[8'h11] = 64'h0001_0001_0001_0001;

    repeat (3) @(negedge clk);
    check_zero_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_op(8'h10, 8'h10, 8'd1, 1'b0);
    check("s1_dot40", 64'(dot_result), 64'd40);
    do_op(8'h10, 8'h10, 8'd2, 1'b0);
    check("s2_dot44", 64'(dot_result), 64'd44);
    do_op(8'h33, 8'h44, 8'd0, 1'b1);
    do_op(8'hFF, 8'h7F, 8'd2, 1'b1);
    @(negedge clk);
    do_abort(8'h20, 8'h30, 8'd3);
    @(negedge clk);
    do_op(8'h10, 8'h10, 8'd1, 1'b0);
    check("s5_dot40", 64'(dot_result), 64'd40);

    ff_mode = 1'b1;
    @(negedge clk);
    do_op(8'h50, 8'h60, 8'd3, 1'b0);
`ifdef MAC_SEQ_SATURATE_EN
    check("s6_sat", 64'(dot_result), 64'h1_FFFF_FFFF);
    check("s6_ovf", 64'(overflow), 1);
`else
    check("s6_wrap", 64'(dot_result), 64'h0_FFFF_FFFD);
    check("s6_ovf", 64'(overflow), 0);
`endif
    ff_mode = 1'b0;

    // Random runs; some start in the idle cycle right after the previous done.
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      do_op(8'($urandom), 8'($urandom), 8'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
